// File: rtl/mpsoc_ext_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpsoc_arb_pkg
//  Purpose  : Shared types, constants and the round-robin selection function
//             for the MPSoC external Blackbone bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mpsoc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int STAT_W  = 16;
    // Largest supported requester count; index width covers 0..15.
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    // Scan (ptr+1) mod n upward with wrap; first set request bit wins.
    // Returns 0 when no request is set (caller qualifies with |req).
    function automatic logic [IDX_W-1:0] rr_select(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [IDX_W-1:0] win;
        logic             found;
        int unsigned      idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % n;
            if (!found && (i <= n) && req[idx[IDX_W-1:0]]) begin
                win   = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpsoc_ext_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mpsoc_ext_bus_arbiter_if
//  Purpose  : Requester-side handshake and Blackbone external bus signals of
//             the external bus arbiter. slave = arbiter view, master = the
//             surrounding system (tiles plus memory port).
//  Revision : 1.0  initial release
// ============================================================================
interface mpsoc_ext_bus_arbiter_if #(
    parameter int NUM_REQ = 8,
    parameter int AW      = 16,
    parameter int DW      = 16
) ();
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ*AW-1:0] req_addr_i;
    logic [NUM_REQ*DW-1:0] req_wdata_i;
    logic [NUM_REQ*2-1:0]  req_we_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [DW-1:0]         rsp_rdata_o;
    logic                  bb_ext_en_o;
    logic [1:0]            bb_ext_we_o;
    logic [AW-1:0]         bb_ext_addr_o;
    logic [DW-1:0]         bb_ext_din_o;
    logic [DW-1:0]         bb_ext_dout_i;
    logic                  busy_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, bb_ext_dout_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output bb_ext_en_o, bb_ext_we_o, bb_ext_addr_o, bb_ext_din_o, busy_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_wdata_i, req_we_i, bb_ext_dout_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  bb_ext_en_o, bb_ext_we_o, bb_ext_addr_o, bb_ext_din_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/mpsoc_ext_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : mpsoc_rr_picker
//  Purpose  : Combinational round-robin priority selector. Given a request
//             vector and the last-granted pointer, returns a one-hot grant,
//             the winner index and an any-request flag.
//  Revision : 1.0  initial release
// ============================================================================
module mpsoc_rr_picker
    import mpsoc_arb_pkg::*;
#(
    parameter int NUM_REQ = 8
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [IDX_W-1:0]   ptr_i,
    output logic      [NUM_REQ-1:0] gnt_o,
    output logic      [IDX_W-1:0]   idx_o,
    output logic                    any_o
);
    logic [MAX_REQ-1:0] w_req;

    assign w_req = MAX_REQ'(req_i);
    assign idx_o = rr_select(w_req, ptr_i, NUM_REQ);
    assign any_o = |req_i;
    assign gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule
`default_nettype wire

// File: rtl/mpsoc_ext_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mpsoc_ext_bus_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing the single Blackbone
//             external memory port among NUM_REQ requesters. One transaction
//             outstanding: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
//  Options  : MPSOC_ARB_STATS_EN adds saturating per-requester grant counters
//             (grant_cnt_o) and a multi-request conflict pulse (conflict_o).
//  Revision : 1.0  initial release
// ============================================================================
module mpsoc_ext_bus_arbiter
    import mpsoc_arb_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int READ_LAT = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mpsoc_ext_bus_arbiter_if.slave  bus
`ifdef MPSOC_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] grant_cnt_o,
    output logic                      conflict_o
`endif
);
    arb_state_t         state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   win_q;
    logic [1:0]         we_q;
    logic [3:0]         cnt_q;
    logic               bb_en_q;
    logic [1:0]         bb_we_q;
    logic [AW-1:0]      bb_addr_q;
    logic [DW-1:0]      bb_din_q;
    logic [NUM_REQ-1:0] ready_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DW-1:0]      rsp_rdata_q;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;

    mpsoc_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i (bus.req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // Bus FSM with registered bus and handshake outputs; every pulse output
    // defaults to 0 and is set only on the edge entering the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            win_q       <= '0;
            we_q        <= '0;
            cnt_q       <= '0;
            bb_en_q     <= 1'b0;
            bb_we_q     <= '0;
            bb_addr_q   <= '0;
            bb_din_q    <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            bb_en_q     <= 1'b0;
            bb_we_q     <= '0;
            bb_addr_q   <= '0;
            bb_din_q    <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (w_any) begin
                        win_q     <= w_idx;
                        rr_ptr_q  <= w_idx;
                        we_q      <= bus.req_we_i[w_idx*2 +: 2];
                        bb_en_q   <= 1'b1;
                        bb_we_q   <= bus.req_we_i[w_idx*2 +: 2];
                        bb_addr_q <= bus.req_addr_i[w_idx*AW +: AW];
                        bb_din_q  <= bus.req_wdata_i[w_idx*DW +: DW];
                        ready_q   <= w_gnt;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q != 2'b00) begin
                        rsp_valid_q <= NUM_REQ'(1) << win_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q   <= 4'(READ_LAT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rsp_valid_q <= NUM_REQ'(1) << win_q;
                        rsp_rdata_q <= bus.bb_ext_dout_i;
                        state_q     <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.bb_ext_en_o   = bb_en_q;
    assign bus.bb_ext_we_o   = bb_we_q;
    assign bus.bb_ext_addr_o = bb_addr_q;
    assign bus.bb_ext_din_o  = bb_din_q;
    assign bus.req_ready_o   = ready_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.busy_o        = (state_q != IDLE);

`ifdef MPSOC_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [NUM_REQ];

    // Saturating grant counters, bumped once per transaction while in ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if ((state_q == ISSUE) && (win_q == IDX_W'(k)) &&
                    (grant_cnt_q[k] != {STAT_W{1'b1}})) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_pack
        assign grant_cnt_o[g*STAT_W +: STAT_W] = grant_cnt_q[g];
    end

    assign conflict_o = (state_q == IDLE) && ($countones(bus.req_valid_i) > 1);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpsoc_ext_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpsoc_ext_bus_arbiter
//  Purpose  : Self-checking bench for mpsoc_ext_bus_arbiter (8 requesters,
//             READ_LAT=3) with a table of per-cycle vectors plus directed
//             multi-cycle sequences. Stats checks build with
//             MPSOC_ARB_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mpsoc_ext_bus_arbiter;
    localparam int NUM_REQ  = 8;
    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int READ_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpsoc_ext_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

`ifdef MPSOC_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_cnt;
    logic                  conflict;
`endif

    mpsoc_ext_bus_arbiter #(
        .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .READ_LAT(READ_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MPSOC_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt),
        .conflict_o  (conflict)
`endif
    );

    // Memory model: read data = addr ^ 16'h1034, valid READ_LAT cycles after
    // the strobe; 16'hDEAD at all other times to expose a mistimed capture.
    logic [1:0]  pv;
    logic [15:0] pd [2];
    always @(posedge clk) begin
        pv[0] <= bus.bb_ext_en_o && (bus.bb_ext_we_o == 2'b00);
        pd[0] <= bus.bb_ext_addr_o ^ 16'h1034;
        pv[1] <= pv[0];
        pd[1] <= pd[0];
        bus.bb_ext_dout_i <= pv[1] ? pd[1] : 16'hDEAD;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Requester k sees addr ^ (k<<4), wdata ^ (k<<8), common we.
    task automatic set_fields(input logic [15:0] a, input logic [15:0] d, input logic [1:0] we);
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_addr_i[k*AW +: AW]  = a ^ 16'(k << 4);
            bus.req_wdata_i[k*DW +: DW] = d ^ 16'(k << 8);
            bus.req_we_i[k*2 +: 2]      = we;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        logic [7:0]  valid;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  we;
        logic [7:0]  e_ready;
        logic [7:0]  e_rsp;
        logic [15:0] e_rdata;
        logic        e_en;
        logic [1:0]  e_bwe;
        logic [15:0] e_baddr;
        logic [15:0] e_bdin;
        logic        e_busy;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int          ng;
        int          order [10];
        int          stamp [10];
        int          rsp_cnt [NUM_REQ];
        int          g;
        logic        seen;
        logic [7:0]  vld;

        bus.req_valid_i = '0;
        set_fields('0, '0, '0);

        // Row = one cycle: inputs driven for that cycle, outputs expected in it.
        //              valid  addr      wdata     we     rdy    rsp    rdata     en    bwe    baddr     bdin      busy
        vecs[0]  = '{8'h04, 16'h0120, 16'hBCEF, 2'b11, 8'h00, 8'h00, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{8'h04, 16'h0120, 16'hBCEF, 2'b11, 8'h04, 8'h00, 16'h0000, 1'b1, 2'b11, 16'h0100, 16'hBEEF, 1'b1};
        vecs[2]  = '{8'h00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h04, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1};
        vecs[3]  = '{8'h00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{8'h20, 16'h0250, 16'h0500, 2'b00, 8'h00, 8'h00, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        vecs[5]  = '{8'h20, 16'h0250, 16'h0500, 2'b00, 8'h20, 8'h00, 16'h0000, 1'b1, 2'b00, 16'h0200, 16'h0000, 1'b1};
        vecs[6]  = '{8'h00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1};
        vecs[7]  = '{8'h00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{8'h00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1};
        vecs[9]  = '{8'h00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h20, 16'h1234, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1};
        vecs[10] = '{8'h00, 16'h0000, 16'h0000, 2'b00, 8'h00, 8'h00, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};

        // Single write by 2, then single read by 5.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), bus.req_ready_o,   vecs[i].e_ready);
            chk($sformatf("vec%0d_rsp", i),   bus.rsp_valid_o,   vecs[i].e_rsp);
            chk($sformatf("vec%0d_rdata", i), bus.rsp_rdata_o,   vecs[i].e_rdata);
            chk($sformatf("vec%0d_en", i),    bus.bb_ext_en_o,   vecs[i].e_en);
            chk($sformatf("vec%0d_bwe", i),   bus.bb_ext_we_o,   vecs[i].e_bwe);
            chk($sformatf("vec%0d_baddr", i), bus.bb_ext_addr_o, vecs[i].e_baddr);
            chk($sformatf("vec%0d_bdin", i),  bus.bb_ext_din_o,  vecs[i].e_bdin);
            chk($sformatf("vec%0d_busy", i),  bus.busy_o,        vecs[i].e_busy);
            set_fields(vecs[i].addr, vecs[i].wdata, vecs[i].we);
            bus.req_valid_i = vecs[i].valid;
        end

        // All eight read together; 0 keeps requesting and must wait its turn.
        do_reset();
        set_fields(16'h0300, 16'h0000, 2'b00);
        bus.req_valid_i = 8'hFF;
        ng = 0;
        for (int k = 0; k < NUM_REQ; k++) rsp_cnt[k] = 0;
        for (int cyc = 0; cyc < 200 && ng < 9; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid_o != 0) begin
                g = oh_idx(bus.rsp_valid_o);
                rsp_cnt[g]++;
                chk($sformatf("all_rdata%0d", g), bus.rsp_rdata_o,
                    (16'h0300 ^ 16'(g << 4)) ^ 16'h1034);
            end
            if (bus.req_ready_o != 0) begin
                chk("all_ready_onehot", $countones(bus.req_ready_o), 1);
                g = oh_idx(bus.req_ready_o);
                order[ng] = g;
                ng++;
                if (g != 0) bus.req_valid_i[g] = 1'b0;
            end
        end
        chk("all_grant_count", ng, 9);
        for (int i = 0; i < ng; i++) chk($sformatf("all_order%0d", i), order[i], i % 8);
        for (int k = 0; k < NUM_REQ; k++) chk($sformatf("all_rsp_cnt%0d", k), rsp_cnt[k], 1);
        bus.req_valid_i = '0;
        repeat (10) @(negedge clk);

        // 3 and 6 writing continuously alternate, one write every 3 cycles.
        do_reset();
        set_fields(16'h0400, 16'h1111, 2'b11);
        bus.req_valid_i = 8'h48;
        ng = 0;
        for (int cyc = 0; cyc < 100 && ng < 6; cyc++) begin
            @(negedge clk);
            if (bus.req_ready_o != 0) begin
                order[ng] = oh_idx(bus.req_ready_o);
                stamp[ng] = cyc;
                ng++;
            end
        end
        chk("alt_grant_count", ng, 6);
        for (int i = 0; i < ng; i++) chk($sformatf("alt_order%0d", i), order[i], (i % 2 == 0) ? 3 : 6);
        for (int i = 1; i < ng; i++) chk($sformatf("alt_gap%0d", i), stamp[i] - stamp[i-1], 3);
        bus.req_valid_i = '0;
        repeat (5) @(negedge clk);

        // Reset during WAIT of a read by 1 aborts it without a response.
        do_reset();
        set_fields(16'h0500, 16'h0000, 2'b00);
        bus.req_valid_i = 8'h02;
        @(negedge clk);
        chk("abort_ready", bus.req_ready_o, 8'h02);
        bus.req_valid_i = '0;
        @(negedge clk);
        chk("abort_busy_wait", bus.busy_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_en",    bus.bb_ext_en_o, 1'b0);
        chk("abort_rsp",   bus.rsp_valid_o, 8'h00);
        chk("abort_rdata", bus.rsp_rdata_o, 16'h0000);
        chk("abort_busy",  bus.busy_o,      1'b0);
        chk("abort_addr",  bus.bb_ext_addr_o, 16'h0000);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | (bus.rsp_valid_o != 0);
        end
        rst = 1'b0;
        bus.req_valid_i = 8'h11;
        vld = 8'h11;
        ng = 0;
        for (int cyc = 0; cyc < 40 && ng < 2; cyc++) begin
            @(negedge clk);
            seen = seen | ((bus.rsp_valid_o & 8'h02) != 0);
            if (bus.req_ready_o != 0) begin
                order[ng] = oh_idx(bus.req_ready_o);
                ng++;
                vld = vld & ~bus.req_ready_o;
                bus.req_valid_i = vld;
            end
        end
        chk("abort_no_rsp", seen, 1'b0);
        chk("post_grant_count", ng, 2);
        chk("post_first", order[0], 0);
        chk("post_second", order[1], 4);
        bus.req_valid_i = '0;
        repeat (6) @(negedge clk);

`ifdef MPSOC_ARB_STATS_EN
        // Lone requester 0 writing: counter saturates, never a conflict.
        do_reset();
        set_fields(16'h0000, 16'h0000, 2'b11);
        bus.req_valid_i = 8'h01;
        seen = 1'b0;
        for (int cyc = 0; cyc < 250000 && grant_cnt[15:0] != 16'hFFFF; cyc++) begin
            @(negedge clk);
            seen = seen | conflict;
        end
        repeat (30) begin
            @(negedge clk);
            seen = seen | conflict;
        end
        chk("stat_saturate", grant_cnt[15:0], 16'hFFFF);
        chk("stat_others",   grant_cnt[NUM_REQ*16-1:16], '0);
        chk("stat_conflict", seen, 1'b0);
        bus.req_valid_i = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
